// File: rtl/intra_pkg.sv
// rtl/intra_pkg.sv - shared pixel types, fill constants and FSM states for the intra edge builder
package intra_pkg;

  localparam int PIX_W  = 30;
  localparam int COMP_W = 10;
  localparam int Y_LSB  = 0;
  localparam int U_LSB  = 10;
  localparam int V_LSB  = 20;

  typedef logic [PIX_W-1:0] pixel_t;

  localparam logic [COMP_W-1:0] EDGE_ABOVE_FILL = 10'h1FF;
  localparam logic [COMP_W-1:0] EDGE_LEFT_FILL  = 10'h201;
  localparam logic [COMP_W-1:0] EDGE_TL_FILL    = 10'h200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_TL,
    ST_LOAD_ABOVE,
    ST_LOAD_LEFT,
    ST_DONE
  } edge_state_t;

  function automatic pixel_t fill_pixel(input logic [COMP_W-1:0] c);
    pixel_t p;
    p[Y_LSB +: COMP_W] = c;
    p[U_LSB +: COMP_W] = c;
    p[V_LSB +: COMP_W] = c;
    return p;
  endfunction

endpackage

// File: rtl/intra_edge_fill.sv
// rtl/intra_edge_fill.sv - combinational edge-availability substitution
module intra_edge_fill
  import intra_pkg::*;
#(
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic               have_above_i,
  input  logic               have_left_i,
  input  logic [W*PIX_W-1:0] above_i,
  input  logic [H*PIX_W-1:0] left_i,
  input  pixel_t             top_left_i,
  output logic [W*PIX_W-1:0] above_o,
  output logic [H*PIX_W-1:0] left_o,
  output pixel_t             top_left_o
);

  always_comb begin
    above_o    = above_i;
    left_o     = left_i;
    top_left_o = top_left_i;
    if (!have_above_i) begin
      for (int j = 0; j < W; j++) begin
        above_o[j*PIX_W +: PIX_W] = have_left_i ? left_i[PIX_W-1:0] : fill_pixel(EDGE_ABOVE_FILL);
      end
    end
    if (!have_left_i) begin
      for (int i = 0; i < H; i++) begin
        left_o[i*PIX_W +: PIX_W] = have_above_i ? above_i[PIX_W-1:0] : fill_pixel(EDGE_LEFT_FILL);
      end
    end
    // Neighbour-0 sources come from the raw inputs, never from already-filled arrays.
    if (!(have_above_i && have_left_i)) begin
      if (have_above_i)     top_left_o = above_i[PIX_W-1:0];
      else if (have_left_i) top_left_o = left_i[PIX_W-1:0];
      else                  top_left_o = fill_pixel(EDGE_TL_FILL);
    end
  end

endmodule

// File: rtl/intra_edge_builder.sv
// rtl/intra_edge_builder.sv - collects one block's neighbour pixels and presents a substituted edge set
module intra_edge_builder
  import intra_pkg::*;
#(
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               have_above,
  input  logic               have_left,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   top_left,
  output logic [W*PIX_W-1:0] above_row,
  output logic [H*PIX_W-1:0] left_col,
  output logic               busy
);

  localparam int IDX_W = $clog2((W > H) ? W : H);

  edge_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               have_above_q, have_above_d;
  logic               have_left_q, have_left_d;
  pixel_t             top_left_q, top_left_d, top_left_wr, top_left_fill;
  logic [W*PIX_W-1:0] above_q, above_d, above_wr, above_fill;
  logic [H*PIX_W-1:0] left_q, left_d, left_wr, left_fill;
  logic               enter_done;
  logic               xfer;

  assign in_ready  = (state_q == ST_LOAD_TL) || (state_q == ST_LOAD_ABOVE) || (state_q == ST_LOAD_LEFT);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign xfer      = in_valid && in_ready;
  assign top_left  = top_left_q;
  assign above_row = above_q;
  assign left_col  = left_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    have_above_d = have_above_q;
    have_left_d  = have_left_q;
    top_left_wr  = top_left_q;
    above_wr     = above_q;
    left_wr      = left_q;
    enter_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          have_above_d = have_above;
          have_left_d  = have_left;
          idx_d        = '0;
          case ({have_above, have_left})
            2'b11:   state_d = ST_LOAD_TL;
            2'b10:   state_d = ST_LOAD_ABOVE;
            2'b01:   state_d = ST_LOAD_LEFT;
            default: begin
              state_d    = ST_DONE;
              enter_done = 1'b1;
            end
          endcase
        end
      end
      ST_LOAD_TL: begin
        if (xfer) begin
          top_left_wr = in_pixel;
          state_d     = ST_LOAD_ABOVE;
        end
      end
      ST_LOAD_ABOVE: begin
        if (xfer) begin
          above_wr[int'(idx_q)*PIX_W +: PIX_W] = in_pixel;
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(W-1)) begin
            idx_d = '0;
            if (have_left_q) begin
              state_d = ST_LOAD_LEFT;
            end else begin
              state_d    = ST_DONE;
              enter_done = 1'b1;
            end
          end
        end
      end
      ST_LOAD_LEFT: begin
        if (xfer) begin
          left_wr[int'(idx_q)*PIX_W +: PIX_W] = in_pixel;
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(H-1)) begin
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fill sees the arrays including this cycle's final write, so the last pixel lands with the fills.
  intra_edge_fill #(.W(W), .H(H)) u_fill (
    .have_above_i (have_above_d),
    .have_left_i  (have_left_d),
    .above_i      (above_wr),
    .left_i       (left_wr),
    .top_left_i   (top_left_wr),
    .above_o      (above_fill),
    .left_o       (left_fill),
    .top_left_o   (top_left_fill)
  );

  always_comb begin
    top_left_d = enter_done ? top_left_fill : top_left_wr;
    above_d    = enter_done ? above_fill    : above_wr;
    left_d     = enter_done ? left_fill     : left_wr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      have_above_q <= 1'b0;
      have_left_q  <= 1'b0;
      top_left_q   <= '0;
      above_q      <= '0;
      left_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      have_above_q <= have_above_d;
      have_left_q  <= have_left_d;
      top_left_q   <= top_left_d;
      above_q      <= above_d;
      left_q       <= left_d;
    end
  end

endmodule

// File: tb/tb_intra_edge_builder.sv
// tb/tb_intra_edge_builder.sv - directed self-checking bench for intra_edge_builder
module tb_intra_edge_builder;

  localparam int W = 8;
  localparam int H = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, have_above, have_left;
  logic          in_valid, in_ready;
  logic [29:0]   in_pixel;
  logic          out_valid, out_ready;
  logic [29:0]   top_left;
  logic [W*30-1:0] above_row;
  logic [H*30-1:0] left_col;
  logic          busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [29:0]     stim [0:31];
  logic [W*30-1:0] exp_above;
  logic [H*30-1:0] exp_left;
  logic [29:0]     exp_tl;

  always #5 clk = ~clk;

  intra_edge_builder #(.W(W), .H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .have_above(have_above), .have_left(have_left),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready),
    .top_left(top_left), .above_row(above_row), .left_col(left_col), .busy(busy)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic a, input logic l);
    @(negedge clk);
    start = 1'b1; have_above = a; have_left = l;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Streams stim[0..n-1] with random in_valid gaps; optionally checks the DONE hand-over.
  task automatic stream(input int n, input bit expect_done, input string tag);
    int k = 0;
    int cyc = 0;
    int early = 0;
    int extra = 0;
    bit x;
    while (k < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (out_valid) early++;
      in_valid = ($urandom_range(0, 2) != 0);
      in_pixel = stim[k];
      x = in_valid && in_ready;
      @(posedge clk);
      if (x) k++;
    end
    #1 in_valid = 1'b0;
    check({tag, "_xfers"}, k, n);
    check({tag, "_early_valid"}, early, 0);
    if (expect_done) begin
      @(negedge clk);
      check({tag, "_out_valid"}, out_valid, 1);
      check({tag, "_in_ready_done"}, in_ready, 0);
      for (int c = 0; c < 4; c++) begin
        in_valid = 1'b1;
        in_pixel = 30'h3ABCDEF;
        if (in_ready) extra++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      check({tag, "_extra_xfers"}, extra, 0);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_tl"}, top_left, exp_tl);
    check({tag, "_above"}, above_row, exp_above);
    check({tag, "_left"}, left_col, exp_left);
  endtask

  task automatic finish_block(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_released"}, {out_valid, busy}, 2'b00);
  endtask

  task automatic load_full_stim();
    stim[0] = 30'h00100401;
    for (int k = 1; k <= 8; k++) stim[k] = 30'(k * 32'h00100401);
    for (int k = 9; k <= 16; k++) stim[k] = 30'h3FF;
    exp_tl = stim[0];
    for (int j = 0; j < W; j++) exp_above[j*30 +: 30] = stim[1+j];
    for (int i = 0; i < H; i++) exp_left[i*30 +: 30] = stim[9+i];
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; start = 1'b0; have_above = 1'b0; have_left = 1'b0;
    in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {in_ready, out_valid, busy}, 3'b000);
    check("rst_data", {top_left, above_row, left_col} == '0, 1);
    rst_n = 1'b1;

    // Both neighbours available
    load_full_stim();
    do_start(1, 1);
    stream(17, 1, "both");
    check_outputs("both");
    finish_block("both");

    // Above only
    stim[0] = 30'h12345678;
    for (int k = 1; k < 8; k++) stim[k] = 30'(k * 32'h00100401);
    for (int j = 0; j < W; j++) exp_above[j*30 +: 30] = stim[j];
    for (int i = 0; i < H; i++) exp_left[i*30 +: 30] = 30'h12345678;
    exp_tl = 30'h12345678;
    do_start(1, 0);
    stream(8, 1, "above_only");
    check_outputs("above_only");
    finish_block("above_only");

    // Left only
    stim[0] = 30'h0ABCDEF0;
    for (int k = 1; k < 8; k++) stim[k] = 30'(32'h3FF - k);
    for (int i = 0; i < H; i++) exp_left[i*30 +: 30] = stim[i];
    for (int j = 0; j < W; j++) exp_above[j*30 +: 30] = 30'h0ABCDEF0;
    exp_tl = 30'h0ABCDEF0;
    do_start(0, 1);
    stream(8, 1, "left_only");
    check_outputs("left_only");
    finish_block("left_only");

    // Neither: fills only, out_valid the cycle after start
    for (int j = 0; j < W; j++) exp_above[j*30 +: 30] = 30'h1FF7FDFF;
    for (int i = 0; i < H; i++) exp_left[i*30 +: 30] = 30'h20180601;
    exp_tl = 30'h20080200;
    do_start(0, 0);
    @(negedge clk);
    check("neither_out_valid", {out_valid, in_ready}, 2'b10);
    check_outputs("neither");

    // Backpressure with stray start pulses
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      start = $urandom_range(0, 1) != 0; have_above = 1'b1; have_left = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      if (!out_valid || in_ready || top_left !== exp_tl || above_row !== exp_above || left_col !== exp_left) bad++;
    end
    check("bp_stable", bad, 0);
    out_ready = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 begin out_ready = 1'b0; start = 1'b0; end
    @(negedge clk);
    check("bp_handshake_start_ignored", {out_valid, busy, in_ready}, 3'b000);

    // Reset mid-block
    load_full_stim();
    do_start(1, 1);
    stream(5, 0, "mid_rst");
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ctrl", {out_valid, in_ready, busy}, 3'b000);
    check("mid_rst_data", {top_left, above_row, left_col} == '0, 1);
    rst_n = 1'b1;
    do_start(1, 1);
    stream(17, 1, "after_rst");
    check_outputs("after_rst");
    finish_block("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
